// File: rtl/simple_io_pkg.sv
// Shared defaults and IN-handshake state encoding for simple_io_port.
package simple_io_pkg;
  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} in_state_e;
endpackage

// File: rtl/simple_io_fifo.sv
// Output FIFO for CPU OUT writes: registered storage, wrapping pointers, occupancy count.
module simple_io_fifo
  import simple_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_ready,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic              drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid & rd_ready;
  // A pop frees the slot in the same cycle, so a write into a full FIFO is accepted then.
  assign push  = wr_en & (~full | pop);
  assign drop  = wr_en & full & ~pop;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/simple_io_port.sv
// CPU I/O port: OUT writes through a FIFO to a display, IN reads a strobed switch word.
// Optional overflow counter output enabled by defining SIMPLE_IO_OVF_CNT_EN.
module simple_io_port
  import simple_io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_wdata,
  output logic              out_full,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              disp_ready,
  input  logic              in_req,
  output logic              in_ack,
  output logic [DATA_W-1:0] in_rdata,
  input  logic [DATA_W-1:0] sw,
  input  logic              sw_strobe,
`ifdef SIMPLE_IO_OVF_CNT_EN
  output logic [7:0]        ovf_cnt,
`endif
  output logic              in_pending
);
  in_state_e         state, state_nxt;
  logic [DATA_W-1:0] hold;
  logic              drop;

  simple_io_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (out_we),
    .wdata   (out_wdata),
    .rd_ready(disp_ready),
    .full    (out_full),
    .valid   (disp_valid),
    .rdata   (disp_data),
    .drop    (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ack    = 1'b0;
    case (state)
      IDLE: if (in_req) state_nxt = in_pending ? ACK : WAIT;
      WAIT: begin
        if (!in_req)         state_nxt = IDLE;
        else if (in_pending) state_nxt = ACK;
      end
      ACK: begin
        in_ack    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (!in_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_rdata is snapshotted on entry to ACK, so a strobe during ACK only refills hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold       <= '0;
      in_pending <= 1'b0;
      in_rdata   <= '0;
    end else begin
      if (sw_strobe) begin
        hold       <= sw;
        in_pending <= 1'b1;
      end else if (state == ACK) begin
        in_pending <= 1'b0;
      end
      if (state_nxt == ACK) in_rdata <= hold;
    end
  end

`ifdef SIMPLE_IO_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_simple_io_port.sv
// Bench for simple_io_port: table-driven FIFO vectors with a queue model, hand sequences for the IN handshake.
module tb_simple_io_port;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NV    = 21;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          out_we, out_full, disp_valid, disp_ready;
  logic [DW-1:0] out_wdata, disp_data;
  logic          in_req, in_ack, sw_strobe, in_pending;
  logic [DW-1:0] in_rdata, sw;
`ifdef SIMPLE_IO_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int drops  = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] in_q[$];

  typedef struct {
    logic          we;
    logic [DW-1:0] wdata;
    logic          rdy;
    logic          exp_full;
    logic          exp_valid;
  } vec_t;
  vec_t vecs[NV];

  simple_io_port #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_we    (out_we),
    .out_wdata (out_wdata),
    .out_full  (out_full),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .disp_ready(disp_ready),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_rdata  (in_rdata),
    .sw        (sw),
    .sw_strobe (sw_strobe),
`ifdef SIMPLE_IO_OVF_CNT_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .in_pending(in_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every sampled cycle also checks any in_ack against the expected-word queue.
  task automatic sample();
    @(negedge clk);
    if (in_ack) begin
      if (in_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got in_ack=1 (rdata %0h) expected 0", in_rdata);
      end else begin
        chk("in_rdata", 32'(in_rdata), 32'(in_q.pop_front()));
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 16'h0012, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 16'h0013, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 16'h00AA, 1'b1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; out_we = 1'b0; out_wdata = '0; disp_ready = 1'b0;
    in_req = 1'b0; sw = '0; sw_strobe = 1'b0;
    #2;
    chk("rst_full",    32'(out_full),   0);
    chk("rst_valid",   32'(disp_valid), 0);
    chk("rst_ack",     32'(in_ack),     0);
    chk("rst_pending", 32'(in_pending), 0);
    chk("rst_rdata",   32'(in_rdata),   0);
`ifdef SIMPLE_IO_OVF_CNT_EN
    chk("rst_ovf",     32'(ovf_cnt),    0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // FIFO vectors: fill, overflow drop, drain, refill, push+pop while full
    for (int i = 0; i < NV; i++) begin
      logic full_m, popped;
      out_we = vecs[i].we; out_wdata = vecs[i].wdata; disp_ready = vecs[i].rdy;
      sample();
      chk($sformatf("full[%0d]", i),  32'(out_full),   32'(vecs[i].exp_full));
      chk($sformatf("valid[%0d]", i), 32'(disp_valid), 32'(vecs[i].exp_valid));
      full_m = (fq.size() == DEPTH);
      popped = vecs[i].rdy && (fq.size() != 0);
      if (popped) chk($sformatf("data[%0d]", i), 32'(disp_data), 32'(fq.pop_front()));
      if (vecs[i].we) begin
        if (!full_m || popped) fq.push_back(vecs[i].wdata);
        else drops++;
      end
      next_cycle();
    end
    out_we = 1'b0; disp_ready = 1'b0;
`ifdef SIMPLE_IO_OVF_CNT_EN
    chk("ovf_cnt", 32'(ovf_cnt), 32'(drops));
`endif

    // pending word, then in_req: ack one cycle later, no second ack while held
    sw = 16'h1234; sw_strobe = 1'b1;
    sample(); chk("pend_before", 32'(in_pending), 0); next_cycle();
    sw_strobe = 1'b0;
    sample(); chk("pend_set", 32'(in_pending), 1); next_cycle();
    in_req = 1'b1; in_q.push_back(16'h1234);
    sample(); chk("ack_early", 32'(in_ack), 0); next_cycle();
    sample(); chk("ack_lat1", 32'(in_ack), 1); next_cycle();
    sample(); chk("ack_once", 32'(in_ack), 0); chk("pend_clr", 32'(in_pending), 0); next_cycle();
    repeat (2) begin sample(); chk("ack_held", 32'(in_ack), 0); next_cycle(); end
    in_req = 1'b0;
    sample(); chk("rdata_hold", 32'(in_rdata), 32'h1234); next_cycle();
    sample(); next_cycle();

    // in_req with nothing pending: ack two cycles after a later strobe
    in_req = 1'b1;
    sample(); next_cycle();
    repeat (5) begin sample(); chk("ack_wait", 32'(in_ack), 0); next_cycle(); end
    sw = 16'hBEEF; sw_strobe = 1'b1; in_q.push_back(16'hBEEF);
    sample(); chk("ack_strobe0", 32'(in_ack), 0); next_cycle();
    sw_strobe = 1'b0;
    sample(); chk("ack_strobe1", 32'(in_ack), 0); next_cycle();
    sample(); chk("ack_strobe2", 32'(in_ack), 1); next_cycle();
    in_req = 1'b0;
    sample(); next_cycle();
    sample(); next_cycle();

    // in_req dropped during WAIT returns to IDLE: later strobes give no ack
    in_req = 1'b1;
    sample(); next_cycle();
    in_req = 1'b0;
    sample(); next_cycle();

    // newest word wins; a strobe during ACK stays pending
    sw = 16'h0011; sw_strobe = 1'b1;
    sample(); next_cycle();
    sw = 16'h0022;
    sample(); next_cycle();
    sw_strobe = 1'b0; in_req = 1'b1; in_q.push_back(16'h0022);
    sample(); chk("ack_041_pre", 32'(in_ack), 0); next_cycle();
    sw = 16'h0033; sw_strobe = 1'b1;
    sample(); chk("ack_041", 32'(in_ack), 1); next_cycle();
    sw_strobe = 1'b0;
    sample();
    chk("pend_after_ack", 32'(in_pending), 1);
    chk("rdata_old_word", 32'(in_rdata), 32'h0022);
    next_cycle();
    in_req = 1'b0;
    sample(); next_cycle();
    in_req = 1'b1; in_q.push_back(16'h0033);
    sample(); next_cycle();
    sample(); chk("ack_new_word", 32'(in_ack), 1); next_cycle();
    in_req = 1'b0;
    sample(); next_cycle();
    sample(); next_cycle();

    // reset while in WAIT with two FIFO entries and a word just captured
    out_we = 1'b1; out_wdata = 16'h0077;
    sample(); next_cycle();
    out_wdata = 16'h0088;
    sample(); next_cycle();
    out_we = 1'b0; in_req = 1'b1;
    sample(); chk("pre_rst_valid", 32'(disp_valid), 1); next_cycle();
    sample(); chk("pre_rst_wait", 32'(in_ack), 0); next_cycle();
    sw = 16'h5555; sw_strobe = 1'b1;
    sample(); next_cycle();
    sw_strobe = 1'b0;
    chk("pre_rst_pend", 32'(in_pending), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",   32'(disp_valid), 0);
    chk("mid_rst_full",    32'(out_full),   0);
    chk("mid_rst_ack",     32'(in_ack),     0);
    chk("mid_rst_pending", 32'(in_pending), 0);
    chk("mid_rst_rdata",   32'(in_rdata),   0);
`ifdef SIMPLE_IO_OVF_CNT_EN
    chk("mid_rst_ovf",     32'(ovf_cnt),    0);
`endif
    in_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      sample();
      chk("post_rst_ack", 32'(in_ack), 0);
      chk("post_rst_valid", 32'(disp_valid), 0);
      next_cycle();
    end
    chk("acks_outstanding", 32'(in_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_io_port.md
SIMPLE_IO_PORT -- requirements
Module: simple_io_port

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning CPU data and switch word width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; the value SHALL be a power of two, 2..16.
REQ-003 Port clk: input, 1 bit; the single clock; all state changes on its rising edge.
REQ-004 Port rst_n: input, 1 bit; reset, asynchronous and active-low.
REQ-005 Port out_we: input, 1 bit; CPU OUT instruction write strobe, one cycle per write.
REQ-006 Port out_wdata: input, DATA_W bits; CPU OUT data.
REQ-007 Port out_full: output, 1 bit; FIFO holds FIFO_DEPTH entries.
REQ-008 Port disp_valid: output, 1 bit; disp_data is valid (FIFO not empty).
REQ-009 Port disp_data: output, DATA_W bits; FIFO head word.
REQ-010 Port disp_ready: input, 1 bit; consumer accepts the head.
REQ-011 Port in_req: input, 1 bit; CPU IN instruction request, held high until in_ack is seen.
REQ-012 Port in_ack: output, 1 bit; one-cycle pulse, in_rdata valid.
REQ-013 Port in_rdata: output, DATA_W bits; returned input word.
REQ-014 Port sw: input, DATA_W bits; switch word.
REQ-015 Port sw_strobe: input, 1 bit; debounced one-cycle capture pulse.
REQ-016 Port in_pending: output, 1 bit; a captured word is waiting.

Function
REQ-017 A push SHALL occur when out_we=1 and either out_full=0 or a pop occurs in the same cycle.
REQ-018 A pop SHALL occur when disp_valid=1 and disp_ready=1, advancing to the next entry in the following cycle.
REQ-019 out_we with out_full=1 and no pop SHALL drop the word, leaving FIFO contents and count unchanged.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-021 Data SHALL be ordered first-in first-out; disp_data SHALL be a registered-array read with zero added latency.
REQ-022 sw_strobe SHALL load sw into the hold register and set in_pending the next cycle; a new strobe while pending SHALL overwrite, so the newest word wins.
REQ-023 The IN FSM states SHALL be IDLE, WAIT, ACK and HOLD.
REQ-024 IDLE with in_req=1 SHALL move to ACK if in_pending=1, else to WAIT.
REQ-025 WAIT SHALL move to ACK the cycle after in_pending becomes 1, and SHALL return to IDLE if in_req drops.
REQ-026 ACK SHALL last exactly one cycle: in_ack=1, in_rdata = hold register, in_pending cleared; the FSM then moves to HOLD.
REQ-027 A sw_strobe in the ACK cycle SHALL deliver the old word and leave the new word pending.
REQ-028 HOLD SHALL wait for in_req=0, then return to IDLE, so no double acknowledge occurs.
REQ-029 The minimum in_req-to-in_ack latency SHALL be 1 cycle when a word is pending.
REQ-030 in_rdata SHALL hold its last acknowledged value outside ACK.

Reset
REQ-031 rst_n=0 SHALL immediately give FSM=IDLE, FIFO empty, pointers=0, in_pending=0, in_ack=0, in_rdata=0, disp_valid=0, out_full=0, and ovf_cnt=0 when present.
REQ-032 Reset mid-transaction SHALL discard FIFO contents and the pending word; no in_ack SHALL follow reset release without a new in_req.

Configuration
REQ-033 With the macro SIMPLE_IO_OVF_CNT_EN defined, the block SHALL add output ovf_cnt (8 bits), incremented on each dropped push and saturating at 255.
REQ-034 Without SIMPLE_IO_OVF_CNT_EN, the ovf_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 Package simple_io_pkg SHALL hold the DATA_W default, the FIFO_DEPTH default and the IN FSM state enum (IDLE, WAIT, ACK, HOLD).
REQ-036 FIFO storage, pointers and count SHALL be one sub-module, simple_io_fifo; the IN FSM and hold register SHALL be in the top level.

Verification
REQ-037 Push 0x0001..0x0004 with disp_ready=0 -> out_full=1; push 0x0005 -> dropped (ovf_cnt=1 if enabled); set disp_ready=1 -> disp_data 0x0001,0x0002,0x0003,0x0004, then disp_valid=0.
REQ-038 FIFO full, out_we plus pop in the same cycle with 0x00AA -> count stays 4; 0x00AA exits last.
REQ-039 sw=0x1234 strobe, then in_req -> in_ack exactly 1 cycle later, in_rdata=0x1234, in_pending=0; holding in_req 3 more cycles -> no second in_ack.
REQ-040 in_req with nothing pending, 5 cycles later sw=0xBEEF strobe -> in_ack 2 cycles after the strobe with in_rdata=0xBEEF.
REQ-041 Strobes 0x0011 then 0x0022 before in_req -> in_rdata=0x0022; strobe 0x0033 in the ACK cycle -> 0x0022 delivered, in_pending=1 afterwards.
REQ-042 rst_n low while in WAIT with 2 FIFO entries -> all outputs return to reset values immediately; after release, in_req low -> in_ack stays 0.
